mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle control FSM that initiates each ALU operation and consumes the ALU's result flags.
- Sequences fetch/decode/execute/memory/writeback for one instruction at a time.
- Drives datapath muxes, register-file and memory strobes, and the 2-bit ALU op code.
- Uses returned flags {V,C,Z} to resolve conditional branches.

Parameters:
- OPW, 6, opcode width (instruction bits [31:26])
- FLW, 3, ALU flag width: [2]=V overflow, [1]=C unsigned borrow (a<b), [0]=Z zero

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from the instruction register
- alu_flags  in  3  combinational flags from the ALU for the current cycle
- mem_ready  in  1  memory handshake; access completes on the cycle it is high
- pc_write  out  1  PC load strobe
- ir_write  out  1  instruction register load strobe
- mem_read  out  1  memory read request (held until mem_ready)
- mem_write  out  1  memory write request (held until mem_ready)
- iord  out  1  0 = address from PC, 1 = address from ALU-out register
- reg_write  out  1  register-file write strobe
- mem_to_reg  out  1  writeback source: 0 = ALU-out, 1 = memory data register
- reg_dst  out  1  destination field: 0 = rt, 1 = rd
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm16
- alu_op  out  2  00 = add, 01 = sub, 10 = and
- pc_src  out  2  00 = ALU result, 01 = branch target register, 10 = jump target
- illegal  out  1  one-cycle pulse on an undefined opcode
- flags_q  out  3  latched flags (see Optional Feature)

Behaviour:
- Reset: state=FETCH. All strobes 0, all mux selects 0, alu_op=00, illegal=0, flags_q=0.
- Reset has priority in any state, including mid-memory wait. Any pending request is dropped the cycle after reset.
- Outputs are Moore-decoded from state, except pc_write in BRANCH, which depends on alu_flags.
- Opcodes:
  - ADD 000000, SUB 000001, AND 000010 (R-type)
  - ADDI 000011
  - LW 000100, SW 000101
  - BEQ 000110, BNE 000111, BLTU 001000
  - J 001001
  - All others illegal.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - Stays while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC+4), go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target precompute).
  - Next state from opcode: R-type->EXEC_R, ADDI->EXEC_I, LW/SW->MEM_ADDR, branches->BRANCH, J->JUMP.
  - Illegal opcode: illegal=1 for one cycle, go to FETCH.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_src_b=00.
  - alu_op: 00 for ADD, 01 for SUB, 10 for AND.
  - Next: ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ALU_WB.
- ALU_WB:
  - Outputs: reg_write=1, mem_to_reg=0.
  - reg_dst=1 if entered from EXEC_R, 0 if from EXEC_I; tracked by a registered bit.
  - Next: FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write = Z for BEQ, !Z for BNE, C for BLTU.
  - Next: FETCH.
- JUMP: pc_src=10, pc_write=1. Next: FETCH.
- Latency with mem_ready high on first request:
  - R-type/ADDI 4 cycles
  - LW 5, SW 4
  - Branch 3, J 3
  - Each memory wait cycle adds 1.
- mem_read and mem_write are never both high. Strobes never assert in reset.

Optional Feature:
- Macro: MC_FLAG_REG_EN.
- Defined:
  - flags_q loads alu_flags at the clock edge ending any EXEC_R with SUB, and at the edge ending BRANCH.
  - Otherwise flags_q holds its value.
  - flags_q clears on reset.
- Undefined: flags_q is constant 0 and no register is inferred.

Test Plan:
- Reset asserted 2 cycles during MEM_RD wait -> next cycle state FETCH, mem_read=1, iord=0, no reg_write, flags_q=0.
- ADD (opcode 000000), mem_ready=1 throughout -> FETCH, DECODE, EXEC_R (alu_op=00), ALU_WB (reg_write=1, reg_dst=1), back to FETCH in 4 cycles.
- LW with mem_ready low 3 cycles in MEM_RD -> mem_read/iord held 4 cycles, then MEM_WB with reg_write=1, mem_to_reg=1; total 8 cycles.
- BEQ with alu_flags=001 -> pc_write=1, pc_src=01 in BRANCH. BNE with alu_flags=001 -> pc_write=0. BLTU with flags 010 -> pc_write=1.
- Opcode 111111 -> illegal pulses exactly 1 cycle in DECODE; no reg_write/mem_write; FETCH follows.
- MC_FLAG_REG_EN defined, SUB with alu_flags=101 -> flags_q=101 after EXEC_R, unchanged through a following ADD.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing, ALU op select, flag-based branching.
// Optional MC_FLAG_REG_EN: latch ALU flags after SUB execute and after branch compare into flags_q.
module mc_control_unit #(
  parameter int OPW = 6,
  parameter int FLW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic [FLW-1:0] alu_flags,
  input  logic           mem_ready,
  output logic           pc_write,
  output logic           ir_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           iord,
  output logic           reg_write,
  output logic           mem_to_reg,
  output logic           reg_dst,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
  output logic           illegal,
  output logic [FLW-1:0] flags_q
);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(3);
  localparam logic [OPW-1:0] OP_LW   = OPW'(4);
  localparam logic [OPW-1:0] OP_SW   = OPW'(5);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(7);
  localparam logic [OPW-1:0] OP_BLTU = OPW'(8);
  localparam logic [OPW-1:0] OP_J    = OPW'(9);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP
  } state_t;

  typedef struct packed {
    logic       mem_read, mem_write, iord, reg_write, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
  } ctl_t;

  state_t state, nxt, dec_tgt;
  ctl_t   ctl_q, ctl;
  logic   bad_op, taken;

  // Moore control word for a state; registered one edge early from the next state.
  function automatic ctl_t decode(state_t s, logic [OPW-1:0] op, logic rdst);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      DECODE: c.alu_src_b = 2'b10;
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = (op == OP_SUB) ? 2'b01 : (op == OP_AND) ? 2'b10 : 2'b00;
      end
      EXEC_I, MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ALU_WB: begin c.reg_write = 1'b1; c.reg_dst = rdst; end
      MEM_RD: begin c.mem_read = 1'b1; c.iord = 1'b1; end
      MEM_WB: begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      MEM_WR: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; end
      JUMP:   c.pc_src = 2'b10;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    dec_tgt = FETCH;
    bad_op  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND:  dec_tgt = EXEC_R;
      OP_ADDI:                 dec_tgt = EXEC_I;
      OP_LW, OP_SW:            dec_tgt = MEM_ADDR;
      OP_BEQ, OP_BNE, OP_BLTU: dec_tgt = BRANCH;
      OP_J:                    dec_tgt = JUMP;
      default:                 bad_op  = 1'b1;
    endcase
  end

  always_comb begin
    nxt = state;
    case (state)
      FETCH:          if (mem_ready) nxt = DECODE;
      DECODE:         nxt = dec_tgt;
      EXEC_R, EXEC_I: nxt = ALU_WB;
      MEM_ADDR:       nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:         if (mem_ready) nxt = MEM_WB;
      MEM_WR:         if (mem_ready) nxt = FETCH;
      default:        nxt = FETCH;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_BEQ:  taken = alu_flags[0];
      OP_BNE:  taken = ~alu_flags[0];
      OP_BLTU: taken = alu_flags[1];
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      ctl_q <= decode(FETCH, opcode, 1'b0);
    end else begin
      state <= nxt;
      ctl_q <= decode(nxt, opcode, state == EXEC_R);
    end
  end

  // Reset masks every output so nothing strobes while reset is held.
  assign ctl        = reset ? '0 : ctl_q;
  assign mem_read   = ctl.mem_read;
  assign mem_write  = ctl.mem_write;
  assign iord       = ctl.iord;
  assign reg_write  = ctl.reg_write;
  assign mem_to_reg = ctl.mem_to_reg;
  assign reg_dst    = ctl.reg_dst;
  assign alu_src_a  = ctl.alu_src_a;
  assign alu_src_b  = ctl.alu_src_b;
  assign alu_op     = ctl.alu_op;
  assign pc_src     = ctl.pc_src;

  assign ir_write = ~reset & (state == FETCH) & mem_ready;
  assign pc_write = ~reset & (((state == FETCH) & mem_ready) | (state == JUMP) |
                              ((state == BRANCH) & taken));
  assign illegal  = ~reset & (state == DECODE) & bad_op;

`ifdef MC_FLAG_REG_EN
  logic [FLW-1:0] flags_r;
  always_ff @(posedge clk) begin
    if (reset) flags_r <= '0;
    else if (((state == EXEC_R) && (opcode == OP_SUB)) || (state == BRANCH)) flags_r <= alu_flags;
  end
  assign flags_q = flags_r;
`else
  logic flags_unused;
  assign flags_unused = alu_flags[FLW-1];
  assign flags_q      = '0;
`endif
endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed table, randomized instruction stream against a per-phase model, reset corners.
module tb_mc_control_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [2:0] alu_flags;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, reg_dst, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [2:0] flags_q;
  int n_chk = 0, n_fail = 0;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal(illegal), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic illegal;
  } vec_t;
  typedef enum {PF, PD, PXR, PXI, PAWB, PMA, PMR, PMWB, PMW, PBR, PJ} ph_t;
  typedef struct {ph_t p; logic r;} step_t;
  typedef struct {logic [5:0] op; logic [2:0] fl; int fw, dw, lat, regw, pcw, ill;} tv_t;

  vec_t act;
  assign act = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, reg_dst,
                alu_src_a, alu_src_b, alu_op, pc_src, illegal};

  logic [2:0] fq = 3'b000;
  tv_t tv[17];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Expected outputs for one phase of an instruction, straight from the control tables.
  function automatic vec_t exp_of(ph_t p, logic [5:0] op, logic [2:0] fl, logic rdy);
    vec_t v;
    logic [1:0] opl;
    v = '0;
    opl = op[1:0];
    case (p)
      PF:   begin v.mem_read = 1; v.alu_src_b = 2'b01; v.ir_write = rdy; v.pc_write = rdy; end
      PD:   begin v.alu_src_b = 2'b10; v.illegal = (op > 6'd9); end
      PXR:  begin v.alu_src_a = 1; v.alu_op = opl; end
      PXI, PMA: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
      PAWB: begin v.reg_write = 1; v.reg_dst = (op < 6'd3); end
      PMR:  begin v.mem_read = 1; v.iord = 1; end
      PMWB: begin v.reg_write = 1; v.mem_to_reg = 1; end
      PMW:  begin v.mem_write = 1; v.iord = 1; end
      PBR:  begin
        v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_src = 2'b01;
        v.pc_write = (op == 6'd6) ? fl[0] : (op == 6'd7) ? ~fl[0] : fl[1];
      end
      PJ:   begin v.pc_src = 2'b10; v.pc_write = 1; end
      default: ;
    endcase
    return v;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [2:0] fl, input int fw, input int dw,
                           output int lat, output int nregw, output int npcw, output int nill);
    step_t q[$];
    step_t st;
    int wc, qlen;
    bit seen_nf, done, fetch_pat;
    for (int i = 0; i <= fw; i++) q.push_back('{PF, (i == fw)});
    q.push_back('{PD, 1'b1});
    if (op < 6'd3) begin q.push_back('{PXR, 1'b1}); q.push_back('{PAWB, 1'b1}); end
    else if (op == 6'd3) begin q.push_back('{PXI, 1'b1}); q.push_back('{PAWB, 1'b1}); end
    else if (op == 6'd4) begin
      q.push_back('{PMA, 1'b1});
      for (int i = 0; i <= dw; i++) q.push_back('{PMR, (i == dw)});
      q.push_back('{PMWB, 1'b1});
    end else if (op == 6'd5) begin
      q.push_back('{PMA, 1'b1});
      for (int i = 0; i <= dw; i++) q.push_back('{PMW, (i == dw)});
    end else if (op < 6'd9) q.push_back('{PBR, 1'b1});
    else if (op == 6'd9) q.push_back('{PJ, 1'b1});
    qlen = q.size();
    opcode = op; alu_flags = fl;
    wc = 0; lat = 0; nregw = 0; npcw = 0; nill = 0; seen_nf = 0; done = 0;
    while (!done && lat < 40) begin
      // memory responder: each request waits fw (fetch) or dw (data) cycles before ready
      mem_ready = (mem_read | mem_write) && (wc >= (iord ? dw : fw));
      #1;
      fetch_pat = mem_read && !iord && (alu_src_b == 2'b01);
      if (lat > 0 && seen_nf && fetch_pat) done = 1;
      else begin
        chk("flags_q", flags_q, fq);
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_cycle: op %0d still busy after %0d cycles, expected %0d", op, lat, qlen);
        end else begin
          st = q.pop_front();
          chk("cycle_outputs", act, exp_of(st.p, op, fl, st.r));
`ifdef MC_FLAG_REG_EN
          if ((st.p == PXR && op == 6'd1) || st.p == PBR) fq = fl;
`endif
        end
        nregw += int'(reg_write); npcw += int'(pc_write); nill += int'(illegal);
        if (mem_read | mem_write) wc = mem_ready ? 0 : wc + 1;
        if (!fetch_pat) seen_nf = 1;
        lat++;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: op %0d never returned to fetch, got %0d cycles", op, lat);
    end
    chk("latency_vs_model", lat, qlen);
  endtask

  initial begin
    int lat, rw, pw, il;
    logic [2:0] fexp;
    tv[0]  = '{6'd0,  3'b000, 0, 0, 4, 1, 1, 0};
    tv[1]  = '{6'd1,  3'b101, 0, 0, 4, 1, 1, 0};
    tv[2]  = '{6'd2,  3'b011, 0, 0, 4, 1, 1, 0};
    tv[3]  = '{6'd3,  3'b000, 0, 0, 4, 1, 1, 0};
    tv[4]  = '{6'd4,  3'b000, 0, 3, 8, 1, 1, 0};
    tv[5]  = '{6'd4,  3'b000, 0, 0, 5, 1, 1, 0};
    tv[6]  = '{6'd5,  3'b000, 0, 2, 6, 0, 1, 0};
    tv[7]  = '{6'd6,  3'b001, 0, 0, 3, 0, 2, 0};
    tv[8]  = '{6'd6,  3'b000, 0, 0, 3, 0, 1, 0};
    tv[9]  = '{6'd7,  3'b001, 0, 0, 3, 0, 1, 0};
    tv[10] = '{6'd7,  3'b000, 0, 0, 3, 0, 2, 0};
    tv[11] = '{6'd8,  3'b010, 0, 0, 3, 0, 2, 0};
    tv[12] = '{6'd8,  3'b101, 0, 0, 3, 0, 1, 0};
    tv[13] = '{6'd9,  3'b000, 0, 0, 3, 0, 2, 0};
    tv[14] = '{6'd63, 3'b000, 0, 0, 2, 0, 1, 1};
    tv[15] = '{6'd0,  3'b000, 2, 0, 6, 1, 1, 0};
    tv[16] = '{6'd5,  3'b000, 0, 0, 4, 0, 1, 0};

    reset = 1; opcode = 0; alu_flags = 0; mem_ready = 0;
    @(posedge clk); #1;
    chk("reset_outputs", act, 0);
    chk("reset_flags", flags_q, 0);
    @(posedge clk); #1;
    reset = 0; #1;
    chk("first_fetch", act, exp_of(PF, 6'd0, 3'b000, 1'b0));

    foreach (tv[i]) begin
      run_instr(tv[i].op, tv[i].fl, tv[i].fw, tv[i].dw, lat, rw, pw, il);
      chk($sformatf("tbl%0d_latency", i), lat, tv[i].lat);
      chk($sformatf("tbl%0d_reg_write", i), rw, tv[i].regw);
      chk($sformatf("tbl%0d_pc_write", i), pw, tv[i].pcw);
      chk($sformatf("tbl%0d_illegal", i), il, tv[i].ill);
    end

    // SUB latches 101; a following ADD must leave it alone
    run_instr(6'd1, 3'b101, 0, 0, lat, rw, pw, il);
    run_instr(6'd0, 3'b010, 1, 0, lat, rw, pw, il);
`ifdef MC_FLAG_REG_EN
    fexp = 3'b101;
`else
    fexp = 3'b000;
`endif
    chk("flags_hold_after_add", flags_q, fexp);

    for (int n = 0; n < 60; n++) begin
      int r;
      logic [5:0] op;
      r = int'($urandom_range(0, 13));
      op = (r >= 12) ? 6'd63 : 6'(r);
      run_instr(op, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), lat, rw, pw, il);
    end

    // reset in the middle of a stalled load
    run_instr(6'd1, 3'b101, 0, 0, lat, rw, pw, il);
    opcode = 6'd4; alu_flags = 3'b000; mem_ready = 1;
    @(posedge clk); #1;
    mem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("memrd_wait", {mem_read, iord, reg_write}, 3'b110);
    reset = 1; #1;
    chk("reset_masks_outputs", act, 0);
    @(posedge clk); #1;
    chk("reset_hold_outputs", act, 0);
    chk("reset_hold_flags", flags_q, 0);
    @(posedge clk); #1;
    reset = 0; #1;
    chk("post_reset_fetch", act, exp_of(PF, 6'd4, 3'b000, 1'b0));
    chk("post_reset_flags", flags_q, 0);
    fq = 3'b000;
    run_instr(6'd3, 3'b000, 0, 0, lat, rw, pw, il);
    chk("post_reset_addi_latency", lat, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
